// File: rtl/fp_misc_pipe.sv
// rtl/fp_misc_pipe.sv - FP move/sign-inject/min-max/I2F staging unit with a buffered writeback port
// Result is registered once, then queued in a DEPTH-entry FIFO in front of the shared writeback port.
module fp_misc_pipe #(
  parameter int FLEN     = 64,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int ID_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [2:0]          issue_op,
  input  logic                issue_single,
  input  logic [ID_WIDTH-1:0] issue_id,
  input  logic [FLEN-1:0]     rs1,
  input  logic [FLEN-1:0]     rs2,
  input  logic [XLEN-1:0]     int_rs,
  output logic                wb_valid,
  input  logic                wb_ack,
  output logic [ID_WIDTH-1:0] wb_id,
  output logic [FLEN-1:0]     wb_rd,
  output logic                wb_nv,
  output logic [6:0]          wb_clz,
  output logic                wb_int_zero
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ID_WIDTH + FLEN + 9;

  localparam logic [2:0] OP_FMV    = 3'b000;
  localparam logic [2:0] OP_FSGNJ  = 3'b001;
  localparam logic [2:0] OP_FSGNJN = 3'b010;
  localparam logic [2:0] OP_FSGNJX = 3'b011;
  localparam logic [2:0] OP_FMIN   = 3'b100;
  localparam logic [2:0] OP_FMAX   = 3'b101;
  localparam logic [2:0] OP_I2F    = 3'b110;

  function automatic logic [31:0] unbox(input logic [FLEN-1:0] v);
    return (&v[FLEN-1:32]) ? v[31:0] : 32'h7FC0_0000;
  endfunction

  function automatic logic [FLEN-1:0] box(input logic [31:0] v);
    return {{(FLEN-32){1'b1}}, v};
  endfunction

  function automatic logic is_nan(input logic [63:0] v, input logic sp);
    return sp ? ((&v[30:23]) && (v[22:0] != 23'h0))
              : ((&v[62:52]) && (v[51:0] != 52'h0));
  endfunction

  function automatic logic is_snan(input logic [63:0] v, input logic sp);
    return is_nan(v, sp) && !(sp ? v[22] : v[51]);
  endfunction

  // Sign-magnitude ordering; differing signs put -0 below +0.
  function automatic logic lt_sm(input logic [63:0] a, input logic [63:0] b, input logic sp);
    logic        sa, sb;
    logic [62:0] ma, mb;
    sa = sp ? a[31] : a[63];
    sb = sp ? b[31] : b[63];
    ma = sp ? {32'h0, a[30:0]} : a[62:0];
    mb = sp ? {32'h0, b[30:0]} : b[62:0];
    if (sa != sb) return sa;
    return sa ? (ma > mb) : (ma < mb);
  endfunction

  logic [63:0]     a_w, b_w, pick;
  logic            sa, sb, sgn;
  logic [XLEN-1:0] mag;
  logic [FLEN-1:0] res_rd;
  logic            res_nv, res_zero;
  logic [6:0]      res_clz;

  always_comb begin
    a_w      = issue_single ? {32'h0, unbox(rs1)} : rs1[63:0];
    b_w      = issue_single ? {32'h0, unbox(rs2)} : rs2[63:0];
    sa       = issue_single ? a_w[31] : a_w[63];
    sb       = issue_single ? b_w[31] : b_w[63];
    sgn      = 1'b0;
    pick     = 64'h0;
    mag      = '0;
    res_rd   = '0;
    res_nv   = 1'b0;
    res_clz  = 7'd0;
    res_zero = 1'b0;
    case (issue_op)
      OP_FMV: res_rd = issue_single ? box(int_rs[31:0]) : FLEN'(int_rs);
      OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
        sgn    = (issue_op == OP_FSGNJ) ? sb : (issue_op == OP_FSGNJN) ? ~sb : (sa ^ sb);
        res_rd = issue_single ? box({sgn, a_w[30:0]}) : {sgn, a_w[62:0]};
      end
      OP_FMIN, OP_FMAX: begin
        res_nv = is_snan(a_w, issue_single) || is_snan(b_w, issue_single);
        if (is_nan(a_w, issue_single) && is_nan(b_w, issue_single))
          pick = issue_single ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
        else if (is_nan(a_w, issue_single))
          pick = b_w;
        else if (is_nan(b_w, issue_single))
          pick = a_w;
        else
          pick = (lt_sm(a_w, b_w, issue_single) == (issue_op == OP_FMIN)) ? a_w : b_w;
        res_rd = issue_single ? box(pick[31:0]) : pick;
      end
      default: begin
        // I2F/I2FU: magnitude staged for the shared normalise/round stage downstream.
        sgn    = (issue_op == OP_I2F) && int_rs[XLEN-1];
        mag    = sgn ? (~int_rs + XLEN'(1)) : int_rs;
        res_rd = FLEN'(mag);
        res_rd[FLEN-1] = res_rd[FLEN-1] | sgn;
        res_clz = 7'(XLEN);
        for (int i = 0; i < XLEN; i++)
          if (mag[i]) res_clz = 7'(XLEN - 1 - i);
        res_zero = (mag == '0);
      end
    endcase
  end

  logic            st_valid;
  logic [EW-1:0]   st_ent;
  logic [EW-1:0]   buf_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     occ;
  logic            accept, push, pop;
  logic [EW-1:0]   head;

  assign occ         = {1'b0, buf_count} + {{CW{1'b0}}, st_valid};
  assign issue_ready = occ < (CW+1)'(DEPTH);
  assign accept      = issue_valid && issue_ready;
  assign push        = st_valid;
  assign wb_valid    = buf_count != '0;
  assign pop         = wb_valid && wb_ack;
  assign head        = buf_mem[rd_ptr];
  assign {wb_id, wb_rd, wb_nv, wb_clz, wb_int_zero} = wb_valid ? head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid  <= 1'b0;
      st_ent    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else if (flush) begin
      st_valid  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      st_valid <= accept;
      if (accept) st_ent <= {issue_id, res_rd, res_nv, res_clz, res_zero};
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      buf_count <= buf_count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) buf_mem[wr_ptr] <= st_ent;
  end

endmodule
